freq_calc: RTL and testbench
============================

# freq_calc

Back-end of the equal-precision frequency meter: consumes the `cnt_s` / `cnt_x` / `irq` triple produced by the meter and converts it to an integer frequency in Hz, `freq = round(cnt_x * CLK_FREQ / cnt_s)`, using a sequential divider. It also supplies the meter's `meas_rst` input: a watchdog pulses `meas_rst` when no new measurement arrives within a timeout, which recovers the divided range after a sudden frequency drop. It sits between the meter and the host/display logic.

## Interface
- `CLK_FREQ`, 100_000_000: reference clock frequency in Hz. Must be < 2^31.
- `IRQ_TIMEOUT`, 200_000_000: number of cycles without an `irq` rising edge before the watchdog fires. Must be ≥ 2.
- `RST_PULSE`, 4: `meas_rst` pulse length in cycles. Must be ≥ 1.

- `clk_100M` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `cnt_s` in 32: reference-clock count from the meter.
- `cnt_x` in 32: signal count from the meter.
- `irq` in 1: measurement-complete level from the meter. Its rising edge means "new counts valid".
- `freq` out 32: last computed frequency in Hz. Held between results.
- `freq_valid` out 1: one-cycle pulse; `freq`, `div_err` and `sat` are updated in the same cycle.
- `div_err` out 1: level. `cnt_s` was 0 in the last result; `freq` = 0.
- `sat` out 1: level. The quotient exceeded 32 bits in the last result; `freq` = 32'hFFFF_FFFF.
- `overrun` out 1: one-cycle pulse. An `irq` edge arrived while busy and was dropped.
- `busy` out 1: high in any state other than IDLE.
- `meas_rst` out 1: reset pulse to the meter's divided range.
- `timeout` out 1: sticky. Set when the watchdog fires; cleared at the next `irq` edge.

## Operation
- **Edge detection:** `irq_q` registers `irq`. An edge is `irq & ~irq_q`, evaluated at each `clk_100M` edge.
- **State machine IDLE → MUL → DIV → DONE → IDLE:**
  - IDLE: on an edge, latch `cnt_s` and `cnt_x`, then go to MUL.
  - MUL: compute `num = cnt_x * CLK_FREQ + (cnt_s >> 1)` as a 64-bit unsigned value. The `cnt_s >> 1` term gives round-half-up. No overflow is possible given the `CLK_FREQ` bound. Go to DIV with the iteration counter at 0.
  - DIV: 64 iterations of restoring division of `num` by the latched `cnt_s`, one quotient bit per cycle, MSB first. Use a 33-bit partial remainder. After iteration 63, go to DONE.
  - DONE: if `cnt_s == 0`, then `freq` = 0, `div_err` = 1, `sat` = 0. Otherwise, if `quotient[63:32] != 0`, then `freq` = 32'hFFFF_FFFF, `sat` = 1. Otherwise `freq` = `quotient[31:0]`, `sat` = 0, `div_err` = 0. Pulse `freq_valid`, then go to IDLE.
  - For `cnt_s == 0`, DIV still runs its full 64 cycles so latency stays constant. The quotient is discarded.
- **Overrun:** an edge seen in MUL, DIV or DONE is dropped and pulses `overrun`. The computation in flight is unaffected.
- **Watchdog:**
  - A 32-bit counter increments every cycle. It clears on an edge (in any state).
  - When the counter reaches `IRQ_TIMEOUT-1`: it clears, `meas_rst` goes high for exactly `RST_PULSE` cycles, and `timeout` is set.
  - An edge during an active `meas_rst` pulse does not shorten the pulse.
  - `freq` keeps its old value on timeout.
- **Simultaneous events:** if an edge and watchdog expiry occur in the same cycle, the edge wins. The counter clears, no pulse is issued, and `timeout` is cleared.

## Timing
- **Reset values:** all outputs 0; state IDLE; `irq_q` = 0; watchdog counter 0.
- **Reset mid-operation:** `rst` asserted in any state aborts the computation. No `freq_valid` is issued, and all outputs return to 0 asynchronously.
- **Latency:** the edge is sampled at clock edge k. MUL is active in cycle k+1, DIV in cycles k+2 to k+65, DONE in k+66. `freq_valid` is high in the cycle following edge k+66, i.e. 66 cycles after the sampling edge.
- **Throughput:** at most one result per 67 cycles. The meter produces results every ≥ 10^6 cycles.
- **`busy`:** high from the cycle after edge k through DONE.
- **`meas_rst`:** registered. It rises in the cycle after the counter hits `IRQ_TIMEOUT-1`.

## Structure
- Shared package `freq_pkg` holds:
  - the state enum (IDLE, MUL, DIV, DONE);
  - the default `CLK_FREQ` constant;
  - the 64/32 width constants.
- Sub-module `seq_div` contains the 64-by-32 restoring divider: start/done handshake, 64-cycle fixed latency, quotient output. `freq_calc` contains the FSM, the multiply/round step, saturation and the watchdog.

## Test plan
- `cnt_s` = 10_000_000, `cnt_x` = 1_000_000, `irq` 0→1: `freq` = 10_000_000, `freq_valid` exactly 66 cycles after the sampling edge, `div_err` = `sat` = 0.
- `cnt_s` = 10_000_003, `cnt_x` = 7: the exact value is 69.99997, so rounding gives `freq` = 70.
- `cnt_s` = 0, `cnt_x` = 5: `freq` = 0, `div_err` = 1, same 66-cycle latency.
- `cnt_s` = 1, `cnt_x` = 4_000_000_000: `freq` = 32'hFFFF_FFFF, `sat` = 1. A following valid measurement clears `sat`.
- `IRQ_TIMEOUT` = 1000, `RST_PULSE` = 4, no edges after reset: `meas_rst` high for 4 cycles starting 1000 cycles after reset release, repeating every 1000 cycles, and `timeout` = 1. An edge clears `timeout` and restarts the count.
- Second `irq` edge 10 cycles into DIV: one `overrun` pulse and the first result is correct. Separately, `rst` pulsed in the middle of DIV: no `freq_valid` and all outputs 0.

Source files
------------

// File: rtl/freq_calc_pkg.sv
// Shared types and constants for the frequency-meter back end.
package freq_pkg;
  localparam int NUM_W = 64;
  localparam int DEN_W = 32;
  localparam logic [31:0] CLK_FREQ_DEF = 32'd100_000_000;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  typedef struct packed {
    logic [DEN_W-1:0] freq;
    logic             div_err;
    logic             sat;
  } result_t;
endpackage

// File: rtl/freq_calc_if.sv
// Meter-side counts/irq in, frequency result and supervision signals out.
interface freq_calc_if;
  import freq_pkg::*;
  logic [DEN_W-1:0] cnt_s;
  logic [DEN_W-1:0] cnt_x;
  logic             irq;
  logic [DEN_W-1:0] freq;
  logic             freq_valid;
  logic             div_err;
  logic             sat;
  logic             overrun;
  logic             busy;
  logic             meas_rst;
  logic             timeout;

  modport master (output cnt_s, cnt_x, irq,
                  input  freq, freq_valid, div_err, sat, overrun, busy, meas_rst, timeout);
  modport slave  (input  cnt_s, cnt_x, irq,
                  output freq, freq_valid, div_err, sat, overrun, busy, meas_rst, timeout);
endinterface

// File: rtl/freq_calc_seq_div.sv
// 64-by-32 restoring divider, one quotient bit per cycle, fixed 64-cycle latency.
module seq_div
  import freq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [NUM_W-1:0] i_num,
  input  logic [DEN_W-1:0] i_den,
  output logic             o_done,
  output logic [NUM_W-1:0] o_quot
);
  logic [NUM_W-1:0] r_q;
  logic [DEN_W-1:0] r_rem;
  logic [DEN_W-1:0] r_den;
  logic [5:0]       r_iter;
  logic             r_run;
  logic [DEN_W:0]   w_trial;
  logic             w_ge;

  // Dividend bits leave r_q at the top while quotient bits enter at the bottom.
  assign w_trial = {r_rem, r_q[NUM_W-1]};
  assign w_ge    = w_trial >= {1'b0, r_den};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q    <= '0;
      r_rem  <= '0;
      r_den  <= '0;
      r_iter <= '0;
      r_run  <= 1'b0;
    end else if (i_start) begin
      r_q    <= i_num;
      r_rem  <= '0;
      r_den  <= i_den;
      r_iter <= '0;
      r_run  <= 1'b1;
    end else if (r_run) begin
      r_q    <= {r_q[NUM_W-2:0], w_ge};
      r_rem  <= w_ge ? DEN_W'(w_trial - {1'b0, r_den}) : w_trial[DEN_W-1:0];
      r_iter <= r_iter + 6'd1;
      if (r_iter == 6'(NUM_W - 1)) r_run <= 1'b0;
    end
  end

  // High during the final iteration; o_quot is complete after the next edge.
  assign o_done = r_run && (r_iter == 6'(NUM_W - 1));
  assign o_quot = r_q;
endmodule

// File: rtl/freq_calc.sv
// Converts meter counts to round(cnt_x*CLK_FREQ/cnt_s) Hz and supervises the
// meter with an irq watchdog that issues meas_rst pulses.
module freq_calc
  import freq_pkg::*;
#(
  parameter logic [31:0] CLK_FREQ    = CLK_FREQ_DEF,
  parameter logic [31:0] IRQ_TIMEOUT = 32'd200_000_000,
  parameter logic [31:0] RST_PULSE   = 32'd4
) (
  input  logic       clk_100M,
  input  logic       rst,
  freq_calc_if.slave bus
);
  state_t           r_state, w_state_nxt;
  logic             r_irq_q, w_edge;
  logic [DEN_W-1:0] r_cnt_s, r_cnt_x;
  logic [NUM_W-1:0] w_num, w_quot;
  logic             w_start, w_div_done, w_expire;
  result_t          w_res, r_res;
  logic             r_freq_valid, r_overrun, r_meas_rst, r_timeout;
  logic [31:0]      r_wdog, r_pcnt;

  assign w_edge   = bus.irq & ~r_irq_q;
  // Adding cnt_s/2 before the truncating divide rounds half up.
  assign w_num    = 64'(r_cnt_x) * 64'(CLK_FREQ) + 64'(r_cnt_s >> 1);
  assign w_expire = ~w_edge & (r_wdog == IRQ_TIMEOUT - 32'd1);

  seq_div u_div (
    .clk     (clk_100M),
    .rst     (rst),
    .i_start (w_start),
    .i_num   (w_num),
    .i_den   (r_cnt_s),
    .o_done  (w_div_done),
    .o_quot  (w_quot)
  );

  always_ff @(posedge clk_100M or posedge rst)
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    case (r_state)
      IDLE:    if (w_edge) w_state_nxt = MUL;
      MUL:     begin w_start = 1'b1; w_state_nxt = DIV; end
      DIV:     if (w_div_done) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // A zero divisor still runs the divider; its quotient is simply ignored.
  always_comb begin
    w_res = '0;
    if (r_cnt_s == '0)                       w_res.div_err = 1'b1;
    else if (w_quot[NUM_W-1:DEN_W] != '0) begin
      w_res.freq = '1;
      w_res.sat  = 1'b1;
    end else                                 w_res.freq = w_quot[DEN_W-1:0];
  end

  always_ff @(posedge clk_100M or posedge rst) begin
    if (rst) begin
      r_irq_q      <= 1'b0;
      r_cnt_s      <= '0;
      r_cnt_x      <= '0;
      r_res        <= '0;
      r_freq_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_irq_q      <= bus.irq;
      if (r_state == IDLE && w_edge) begin
        r_cnt_s <= bus.cnt_s;
        r_cnt_x <= bus.cnt_x;
      end
      if (r_state == DONE) r_res <= w_res;
      r_freq_valid <= (r_state == DONE);
      r_overrun    <= w_edge & (r_state != IDLE);
    end
  end

  // Watchdog: an irq edge always wins over a same-cycle expiry.
  always_ff @(posedge clk_100M or posedge rst) begin
    if (rst) begin
      r_wdog     <= '0;
      r_pcnt     <= '0;
      r_meas_rst <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      if (w_edge) begin
        r_wdog    <= '0;
        r_timeout <= 1'b0;
      end else if (w_expire) begin
        r_wdog    <= '0;
        r_timeout <= 1'b1;
      end else begin
        r_wdog    <= r_wdog + 32'd1;
      end
      if (w_expire) begin
        r_meas_rst <= 1'b1;
        r_pcnt     <= RST_PULSE - 32'd1;
      end else if (r_pcnt != '0) begin
        r_pcnt     <= r_pcnt - 32'd1;
      end else begin
        r_meas_rst <= 1'b0;
      end
    end
  end

  assign bus.freq       = r_res.freq;
  assign bus.div_err    = r_res.div_err;
  assign bus.sat        = r_res.sat;
  assign bus.freq_valid = r_freq_valid;
  assign bus.overrun    = r_overrun;
  assign bus.busy       = (r_state != IDLE);
  assign bus.meas_rst   = r_meas_rst;
  assign bus.timeout    = r_timeout;
endmodule

// File: tb/tb_freq_calc.sv
// Bench for freq_calc: timing-level reference model checked every cycle,
// directed scenarios with literal expectations, plus randomized measurements.
module tb_freq_calc;
  localparam logic [31:0] CLK_HZ = 32'd100_000_000;
  localparam int          TO     = 1000;
  localparam int          PULSE  = 4;
  localparam int          LAT    = 66;

  logic clk = 1'b0;
  logic rst = 1'b1;
  freq_calc_if bus();

  freq_calc #(.CLK_FREQ(CLK_HZ), .IRQ_TIMEOUT(32'(TO)), .RST_PULSE(32'(PULSE))) dut (
    .clk_100M (clk),
    .rst      (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0;
  int cyc = 0;
  int fv_q[$];
  int mr_q[$];
  int ovr_cnt = 0;
  logic mr_prev = 1'b0;

  // model state
  logic [33:0] m_res;
  bit          m_valid, m_ovr, m_job, m_irq_q, m_timeout;
  int          m_job_at, m_base, m_pulse_end;
  logic [31:0] m_jcs, m_jcx;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // {freq, div_err, sat} from the defining formula.
  function automatic logic [33:0] ref_calc(input logic [31:0] cs, input logic [31:0] cx);
    longint unsigned num, q;
    if (cs == 32'd0) return {32'd0, 1'b1, 1'b0};
    num = 64'(cx) * 64'(CLK_HZ) + 64'(cs >> 1);
    q   = num / 64'(cs);
    if (q > 64'h0000_0000_FFFF_FFFF) return {32'hFFFF_FFFF, 1'b0, 1'b1};
    return {q[31:0], 2'b00};
  endfunction

  task automatic model_reset();
    m_res = '0; m_valid = 0; m_ovr = 0; m_job = 0; m_irq_q = 0; m_timeout = 0;
    m_job_at = 0; m_base = cyc; m_pulse_end = 0; m_jcs = '0; m_jcx = '0;
  endtask

  // One clock edge of behaviour, n = cyc, using inputs stable at the edge.
  task automatic model_step();
    bit e, busy_pre;
    if (rst) begin model_reset(); return; end
    e = bus.irq && !m_irq_q;
    m_irq_q = bus.irq;
    m_valid = 0; m_ovr = 0;
    busy_pre = m_job;
    if (m_job && cyc == m_job_at + LAT) begin
      m_valid = 1; m_res = ref_calc(m_jcs, m_jcx); m_job = 0;
    end
    if (e) begin
      if (busy_pre) m_ovr = 1;
      else begin m_job = 1; m_job_at = cyc; m_jcs = bus.cnt_s; m_jcx = bus.cnt_x; end
    end
    if (e) begin
      m_base = cyc; m_timeout = 0;
    end else if (cyc - m_base == TO) begin
      m_base = cyc; m_timeout = 1; m_pulse_end = cyc + PULSE;
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    model_step();
    #4;
    if (rst) model_reset();
    chk("outputs {freq,err,sat,valid,ovr,busy,mrst,tmo}",
        {25'd0, bus.freq, bus.div_err, bus.sat, bus.freq_valid, bus.overrun,
         bus.busy, bus.meas_rst, bus.timeout},
        {25'd0, m_res, m_valid, m_ovr, m_job, (cyc < m_pulse_end), m_timeout});
    if (bus.freq_valid) fv_q.push_back(cyc);
    if (bus.meas_rst && !mr_prev) mr_q.push_back(cyc);
    mr_prev = bus.meas_rst;
    if (bus.overrun) ovr_cnt++;
  end

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #2;
  endtask

  // Raise irq so it is sampled at the next edge s; drop it three edges later.
  task automatic meas(input logic [31:0] cs, input logic [31:0] cx, output int s);
    fv_q.delete();
    bus.cnt_s = cs; bus.cnt_x = cx; bus.irq = 1'b1; s = cyc + 1;
    tick(3);
    bus.irq = 1'b0;
  endtask

  task automatic wait_valid(input int s, input logic [31:0] ef, input logic ee,
                            input logic es, input string nm);
    int t = 0;
    while (fv_q.size() == 0 && t < 150) begin tick(1); t++; end
    chk({nm, " valid seen"}, 64'(fv_q.size() != 0), 64'd1);
    if (fv_q.size() == 0) return;
    chk({nm, " latency"}, 64'(fv_q.pop_front() - s), 64'(LAT));
    chk({nm, " result"}, {30'd0, bus.freq, bus.div_err, bus.sat}, {30'd0, ef, ee, es});
  endtask

  initial begin
    int s, b, o0, nmr;
    logic [31:0] cs;
    bus.irq = 1'b0; bus.cnt_s = '0; bus.cnt_x = '0;
    tick(3);
    chk("reset outputs", {25'd0, bus.freq, bus.div_err, bus.sat, bus.freq_valid,
        bus.overrun, bus.busy, bus.meas_rst, bus.timeout}, 64'd0);
    chk("model 10M", 64'(ref_calc(32'd10_000_000, 32'd1_000_000)), 64'({32'd10_000_000, 2'b00}));
    chk("model round", 64'(ref_calc(32'd10_000_003, 32'd7)), 64'({32'd70, 2'b00}));
    chk("model div0", 64'(ref_calc(32'd0, 32'd5)), 64'({32'd0, 2'b10}));
    chk("model sat", 64'(ref_calc(32'd1, 32'd4_000_000_000)), 64'({32'hFFFF_FFFF, 2'b01}));
    rst = 1'b0;

    meas(32'd10_000_000, 32'd1_000_000, s); wait_valid(s, 32'd10_000_000, 0, 0, "10MHz");
    tick(4);
    meas(32'd10_000_003, 32'd7, s);         wait_valid(s, 32'd70, 0, 0, "rounding");
    tick(4);
    meas(32'd0, 32'd5, s);                  wait_valid(s, 32'd0, 1, 0, "div by zero");
    tick(4);
    meas(32'd1, 32'd4_000_000_000, s);      wait_valid(s, 32'hFFFF_FFFF, 0, 1, "saturate");
    tick(4);
    meas(32'd10_000_000, 32'd3_000_000, s); wait_valid(s, 32'd30_000_000, 0, 0, "sat cleared");
    tick(4);

    // second edge lands ~10 cycles into DIV with different counts
    o0 = ovr_cnt;
    meas(32'd50_000_000, 32'd12_345, s);
    tick(8);
    bus.cnt_s = 32'd7; bus.cnt_x = 32'd7; bus.irq = 1'b1;
    tick(2);
    bus.irq = 1'b0;
    wait_valid(s, 32'd24_690, 0, 0, "overrun first result");
    chk("overrun pulses", 64'(ovr_cnt - o0), 64'd1);
    tick(4);

    for (int i = 0; i < 14; i++) begin
      case ($urandom_range(0, 3))
        0:       cs = 32'd0;
        1:       cs = 32'($urandom_range(1, 1000));
        2:       cs = 32'($urandom_range(1_000_000, 200_000_000));
        default: cs = 32'($urandom);
      endcase
      bus.cnt_s = cs; bus.cnt_x = 32'($urandom); bus.irq = 1'b1;
      tick(2);
      bus.irq = 1'b0;
      tick(int'($urandom_range(40, 120)));
    end
    tick(80);

    // reset in the middle of DIV aborts the result
    meas(32'd123_456, 32'd789, s);
    tick(20);
    rst = 1'b1;
    tick(1);
    chk("abort outputs", {25'd0, bus.freq, bus.div_err, bus.sat, bus.freq_valid,
        bus.overrun, bus.busy, bus.meas_rst, bus.timeout}, 64'd0);
    tick(1);
    rst = 1'b0; b = cyc; fv_q.delete(); mr_q.delete();
    tick(80);
    chk("no valid after abort", 64'(fv_q.size()), 64'd0);

    // watchdog with no edges after reset release
    tick(2010 - 80);
    chk("wd pulse count", 64'(mr_q.size()), 64'd2);
    if (mr_q.size() >= 2) begin
      chk("wd first rise", 64'(mr_q[0] - b), 64'd1000);
      chk("wd second rise", 64'(mr_q[1] - b), 64'd2000);
    end
    chk("timeout set", 64'(bus.timeout), 64'd1);
    meas(32'd1_000, 32'd10, s);
    chk("timeout cleared", 64'(bus.timeout), 64'd0);
    mr_q.delete();
    while (cyc < s + 1005) tick(1);
    chk("wd restart count", 64'(mr_q.size()), 64'd1);
    if (mr_q.size() >= 1) chk("wd restart rise", 64'(mr_q[0] - s), 64'd1000);
    chk("timeout set again", 64'(bus.timeout), 64'd1);

    // edge coincides with watchdog expiry: edge wins
    while (cyc < s + 1999) tick(1);
    mr_q.delete();
    bus.irq = 1'b1;
    tick(3);
    bus.irq = 1'b0;
    tick(20);
    nmr = mr_q.size();
    chk("no pulse on coincident edge", 64'(nmr), 64'd0);
    chk("timeout cleared by coincident edge", 64'(bus.timeout), 64'd0);
    tick(70);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
